// File: rtl/mips_pkg.sv
// Shared load/store types for the MIPS core and its memory unit: op codes, response
// error codes, FSM states, and op classification helpers.
package mips_pkg;

  typedef enum logic [3:0] {
    OpLb  = 4'd0,
    OpLbu = 4'd1,
    OpLh  = 4'd2,
    OpLhu = 4'd3,
    OpLw  = 4'd4,
    OpLwl = 4'd5,
    OpLwr = 4'd6,
    OpSb  = 4'd7,
    OpSh  = 4'd8,
    OpSw  = 4'd9
  } mem_op_t;

  typedef enum logic [1:0] {
    ErrOk         = 2'd0,
    ErrMisaligned = 2'd1,
    ErrTimeout    = 2'd2
  } rsp_err_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } mem_state_t;

  // Loads occupy the low end of the op encoding.
  function automatic logic is_load(mem_op_t op);
    return op <= OpLwr;
  endfunction

  function automatic logic is_misaligned(mem_op_t op, logic [1:0] a);
    case (op)
      OpLh, OpLhu, OpSh: return a[0];
      OpLw, OpSw:        return |a;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_unit_if.sv
// Avalon-MM host-side bus bundle for the load/store unit.
interface mips_mem_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic                waitrequest;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_load_align.sv
// Combinational load result formatting: byte/halfword extraction with sign or zero
// extension, and the LWL/LWR merge with the old rt value.
module mips_load_align
  import mips_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  b,
  input  mem_op_t     op,
  input  logic [31:0] rt,
  output logic [31:0] result
);
  logic [4:0]  sh_r;
  logic [4:0]  sh_l;
  logic [31:0] shr;

  assign sh_r = {b, 3'b000};
  assign sh_l = {~b, 3'b000};
  assign shr  = word >> sh_r;

  always_comb begin
    result = word;
    case (op)
      OpLb:    result = {{24{shr[7]}}, shr[7:0]};
      OpLbu:   result = {24'h0, shr[7:0]};
      OpLh:    result = {{16{shr[15]}}, shr[15:0]};
      OpLhu:   result = {16'h0, shr[15:0]};
      OpLwl:   result = (word << sh_l) | (rt & ~(32'hFFFF_FFFF << sh_l));
      OpLwr:   result = shr | (rt & ~(32'hFFFF_FFFF >> sh_r));
      default: result = word;
    endcase
  end
endmodule

// File: rtl/mips_mem_unit.sv
// Avalon-MM load/store unit for the multi-cycle MIPS core.
// Optional waitrequest watchdog: define MIPS_MEM_TIMEOUT_EN.
module mips_mem_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  mem_op_t           req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output rsp_err_t          rsp_err,
  mips_mem_unit_if.master   bus
);
  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("mips_mem_unit: DATA_W must be 32 or 64 and TIMEOUT_CYCLES nonzero");
  end

  mem_state_t          state_q, state_d;
  rsp_err_t            err_q, err_d;
  mem_op_t             op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         rt_q, word_q, rd_word, align_out;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic [NumBytes-1:0] be_q, be_d;
  logic [OffW-1:0]     req_off;
  logic                capture, timeout;

  assign req_off = req_addr[OffW-1:0];

  if (DATA_W == 64) begin : g_lane64
    assign rd_word = addr_q[2] ? bus.readdata[63:32] : bus.readdata[31:0];
  end else begin : g_lane32
    assign rd_word = bus.readdata[31:0];
  end

`ifdef MIPS_MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                cnt_q <= '0;
    else if (state_q != StBus) cnt_q <= '0;
    else if (bus.waitrequest) cnt_q <= cnt_q + 1'b1;
  end

  // Fires on the stalled cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout = (state_q == StBus) && bus.waitrequest &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Byte lanes and lane-shifted store data; loads enable every lane.
  always_comb begin
    be_d = '1;
    wd_d = '0;
    case (req_op)
      OpSb: begin
        be_d = NumBytes'(1) << req_off;
        wd_d = DATA_W'(req_wdata[7:0]) << (8 * req_off);
      end
      OpSh: begin
        be_d = NumBytes'(3) << req_off;
        wd_d = DATA_W'(req_wdata[15:0]) << (8 * req_off);
      end
      OpSw: begin
        be_d = NumBytes'(15) << req_off;
        wd_d = DATA_W'(req_wdata) << (8 * req_off);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (is_misaligned(req_op, req_addr[1:0])) begin
            err_d   = ErrMisaligned;
            state_d = StResp;
          end else begin
            err_d   = ErrOk;
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (!bus.waitrequest) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (timeout) begin
          err_d   = ErrTimeout;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      err_q   <= ErrOk;
      op_q    <= OpLb;
      addr_q  <= '0;
      rt_q    <= '0;
      word_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (state_q == StIdle && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        rt_q   <= req_rt;
        wd_q   <= wd_d;
        be_q   <= be_d;
      end
      if (capture) word_q <= rd_word;
    end
  end

  mips_load_align u_align (
    .word   (word_q),
    .b      (addr_q[1:0]),
    .op     (op_q),
    .rt     (rt_q),
    .result (align_out)
  );

  // Outputs decode only registered state, so readdata/waitrequest never reach them directly.
  assign req_ready      = (state_q == StIdle);
  assign rsp_valid      = (state_q == StResp);
  assign rsp_err        = rsp_valid ? err_q : ErrOk;
  assign rsp_rdata      = (rsp_valid && err_q == ErrOk && is_load(op_q)) ? align_out : '0;
  assign bus.read       = (state_q == StBus) && is_load(op_q);
  assign bus.write      = (state_q == StBus) && !is_load(op_q);
  assign bus.address    = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign bus.writedata  = wd_q;
  assign bus.byteenable = be_q;

endmodule

// File: tb/tb_mips_mem_unit.sv
// Directed bench for mips_mem_unit: 32- and 64-bit bus instances, hand-computed vectors.
module tb_mips_mem_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        sel64 = 1'b0;
  mem_op_t     req_op = OpLb;
  logic [31:0] req_addr = '0, req_wdata = '0, req_rt = '0;

  logic        ready32, ready64, rv32, rv64;
  logic [31:0] rdata32, rdata64;
  rsp_err_t    err32, err64;

  int n_cmp = 0;
  int n_err = 0;

  mips_mem_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  mips_mem_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  mips_mem_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid & ~sel64),
    .req_ready (ready32),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rt    (req_rt),
    .rsp_valid (rv32),
    .rsp_rdata (rdata32),
    .rsp_err   (err32),
    .bus       (b32)
  );

  mips_mem_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYCLES(8)) u_dut64 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid & sel64),
    .req_ready (ready64),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rt    (req_rt),
    .rsp_valid (rv64),
    .rsp_rdata (rdata64),
    .rsp_err   (err64),
    .bus       (b64)
  );

  always #5 clk = ~clk;

  logic        m_ready, m_rv, m_read, m_write;
  logic [31:0] m_rdata, m_addr;
  logic [1:0]  m_err;
  logic [7:0]  m_be;
  logic [63:0] m_wd;

  assign m_ready = sel64 ? ready64 : ready32;
  assign m_rv    = sel64 ? rv64 : rv32;
  assign m_rdata = sel64 ? rdata64 : rdata32;
  assign m_err   = sel64 ? err64 : err32;
  assign m_read  = sel64 ? b64.read : b32.read;
  assign m_write = sel64 ? b64.write : b32.write;
  assign m_addr  = sel64 ? b64.address : b32.address;
  assign m_be    = sel64 ? b64.byteenable : {4'h0, b32.byteenable};
  assign m_wd    = sel64 ? b64.writedata : {32'h0, b32.writedata};

  int          n_rd, n_wr, rsp_cyc;
  logic [31:0] got_addr, got_rdata;
  logic [7:0]  got_be;
  logic [63:0] got_wd;
  logic [1:0]  got_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request from an idle unit; cycle 0 is the accept cycle. Returns #1 after the
  // edge that ends the response cycle (or after the 40-cycle bound).
  task automatic xact(input logic s64, input mem_op_t op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rt,
                      input logic [63:0] rd, input int waits);
    sel64 = s64; req_op = op; req_addr = addr; req_wdata = wdata; req_rt = rt;
    b32.readdata = rd[31:0];
    b64.readdata = rd;
    n_rd = 0; n_wr = 0; rsp_cyc = -1;
    got_addr = '0; got_be = '0; got_wd = '0; got_rdata = '0; got_err = '0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
      b32.waitrequest = (c <= waits);
      b64.waitrequest = (c <= waits);
      @(negedge clk);
      if (m_read) n_rd++;
      if (m_write) n_wr++;
      if (m_read || m_write) begin
        got_addr = m_addr; got_be = m_be; got_wd = m_wd;
      end
      if (m_rv) begin
        rsp_cyc = c; got_rdata = m_rdata; got_err = m_err;
      end
      @(posedge clk); #1;
    end
    b32.waitrequest = 1'b0;
    b64.waitrequest = 1'b0;
  endtask

  int rv_seen;

  initial begin
    b32.waitrequest = 1'b0; b32.readdata = '0;
    b64.waitrequest = 1'b0; b64.readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready32, 1);
    check("rst_rsp_valid", rv32, 0);
    check("rst_read_write", {b32.read, b32.write}, 0);
    check("rst_address", b32.address, 0);
    check("rst_be_wd", {b32.byteenable, b32.writedata}, 0);
    check("rst_rdata_err", {rdata32, err32}, 0);
    reset = 1'b0;

    xact(0, OpLw, 32'h1000, 0, 0, 64'hDEADBEEF, 2);
    check("lw_wait_read_cycles", n_rd, 3);
    check("lw_wait_address", got_addr, 32'h1000);
    check("lw_wait_be", got_be, 8'h0F);
    check("lw_wait_rsp_cycle", rsp_cyc, 4);
    check("lw_wait_rdata", got_rdata, 32'hDEADBEEF);
    check("lw_wait_err", got_err, 0);

    xact(0, OpLw, 32'h2000, 0, 0, 64'h0BADF00D, 0);
    check("lw_zw_rsp_cycle", rsp_cyc, 2);
    check("lw_zw_read_cycles", n_rd, 1);
    check("lw_zw_ready_c3", m_ready, 1);
    check("lw_zw_rdata", got_rdata, 32'h0BADF00D);

    xact(0, OpLb, 32'h1003, 0, 0, 64'h80FF0000, 0);
    check("lb_rdata", got_rdata, 32'hFFFFFF80);
    check("lb_address", got_addr, 32'h1000);
    xact(0, OpLbu, 32'h1003, 0, 0, 64'h80FF0000, 0);
    check("lbu_rdata", got_rdata, 32'h00000080);
    xact(0, OpLh, 32'h1002, 0, 0, 64'h80FF0000, 0);
    check("lh_rdata", got_rdata, 32'hFFFF80FF);
    xact(0, OpLhu, 32'h1002, 0, 0, 64'h80FF0000, 1);
    check("lhu_rdata", got_rdata, 32'h000080FF);
    check("lhu_rsp_cycle", rsp_cyc, 3);

    xact(0, OpSh, 32'h1002, 32'h1234ABCD, 0, 0, 0);
    check("sh_write_cycles", {n_wr, n_rd}, {32'd1, 32'd0});
    check("sh_be", got_be, 8'h0C);
    check("sh_wd", got_wd, 64'hABCD0000);
    check("sh_rsp", {got_rdata, got_err}, 0);
    xact(0, OpSb, 32'h1001, 32'h000000A5, 0, 0, 0);
    check("sb_be", got_be, 8'h02);
    check("sb_wd", got_wd, 64'h0000A500);
    xact(0, OpSw, 32'h1000, 32'h11223344, 0, 0, 1);
    check("sw_be", got_be, 8'h0F);
    check("sw_wd", got_wd, 64'h11223344);
    check("sw_write_cycles", n_wr, 2);

    xact(0, OpLwl, 32'h1001, 0, 32'hAABBCCDD, 64'h44332211, 0);
    check("lwl_rdata", got_rdata, 32'h2211CCDD);
    xact(0, OpLwr, 32'h1001, 0, 32'hAABBCCDD, 64'h44332211, 0);
    check("lwr_rdata", got_rdata, 32'hAA443322);
    xact(0, OpLwr, 32'h1000, 0, 32'hAABBCCDD, 64'h44332211, 0);
    check("lwr_b0_rdata", got_rdata, 32'h44332211);

    xact(0, OpLw, 32'h1002, 0, 0, 64'hDEADBEEF, 0);
    check("mis_lw_strobes", n_rd + n_wr, 0);
    check("mis_lw_rsp_cycle", rsp_cyc, 1);
    check("mis_lw_err", got_err, 1);
    check("mis_lw_rdata", got_rdata, 0);
    check("mis_ready_after", m_ready, 1);
    xact(0, OpSh, 32'h1001, 32'h1234, 0, 0, 0);
    check("mis_sh_err", {n_wr, 30'd0, got_err}, 64'd1);

    xact(1, OpSw, 32'h1004, 32'hCAFEF00D, 0, 0, 0);
    check("w64_sw_be", got_be, 8'hF0);
    check("w64_sw_wd", got_wd, 64'hCAFEF00D_00000000);
    check("w64_sw_address", got_addr, 32'h1000);
    xact(1, OpLw, 32'h1004, 0, 0, 64'h55667788_11223344, 0);
    check("w64_lw_upper", got_rdata, 32'h55667788);
    xact(1, OpLbu, 32'h1001, 0, 0, 64'h55667788_11223344, 0);
    check("w64_lbu_lower", got_rdata, 32'h00000033);

    // waitrequest held high for the whole request
    xact(0, OpLw, 32'h3000, 0, 0, 64'h12345678, 1000);
`ifdef MIPS_MEM_TIMEOUT_EN
    check("to_read_cycles", n_rd, 8);
    check("to_rsp_cycle", rsp_cyc, 9);
    check("to_err", got_err, 2);
    check("to_rdata", got_rdata, 0);
`else
    check("noto_read_held", n_rd, 40);
    check("noto_no_rsp", rsp_cyc, -1);
`endif
    reset = 1'b1;
    #2;
    reset = 1'b0;

    sel64 = 1'b0; req_op = OpLw; req_addr = 32'h4000;
    b32.waitrequest = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall_read_before", b32.read, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_stall_read_drop", b32.read, 0);
    check("rst_stall_ready", ready32, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    b32.waitrequest = 1'b0;
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rv32) rv_seen++;
    end
    check("rst_stall_no_rsp", rv_seen, 0);
    check("rst_stall_ready_after", ready32, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mem_unit.md
# mips_mem_unit

Parametrised Avalon-MM load/store unit between the multi-cycle MIPS core and the memory bus. Accepts one load/store request at a time from the core, generates the byte-lane `byteenable` and `writedata` for sub-word stores, and holds the bus transaction across `waitrequest`. It also returns sign- or zero-extended, LWL/LWR-merged load results. Generalises the core's single fixed 32-bit bus access to configurable bus and address widths, and adds alignment and timeout error reporting.

## Interface
- `DATA_W`, 32: bus data width; legal values 32 or 64; `byteenable` is DATA_W/8 bits.
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT_CYCLES`, 256: waitrequest watchdog limit; used only when the watchdog is compiled in.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  unit idle and able to accept a request; reset value 1.
- `req_op`  in  4  `mem_op_t`: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data (rt).
- `req_rt`  in  32  current rt value, used by the LWL/LWR merge.
- `rsp_valid`  out  1  one-cycle completion pulse; reset value 0.
- `rsp_rdata`  out  32  load result; 0 for stores and errors; reset value 0.
- `rsp_err`  out  2  `rsp_err_t`: 0 OK, 1 MISALIGNED, 2 TIMEOUT; reset value 0.
- `address`  out  ADDR_W  DATA_W/8-aligned bus address; reset value 0.
- `read`, `write`  out  1  Avalon strobes; reset value 0.
- `waitrequest`  in  1  slave stall.
- `writedata`  out  DATA_W  lane-shifted store data; reset value 0.
- `byteenable`  out  DATA_W/8  active lanes; reset value 0.
- `readdata`  in  DATA_W  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: `req_ready`=1. When `req_valid` is high, the unit registers op, address and data. If the request is misaligned, it goes to RESP with MISALIGNED; otherwise it goes to BUS.
- Misaligned means: LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0. LB-class, LWL and LWR are never misaligned.
- BUS: `read` is asserted (loads) or `write` is asserted (stores), with `address` = req_addr with the low log2(DATA_W/8) bits cleared. `address`, `writedata` and `byteenable` stay stable while `waitrequest`=1.
- In the first BUS cycle with `waitrequest`=0, the transfer completes, `readdata` is captured, and the FSM goes to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then the FSM returns to IDLE.
- Lane selection: k = addr[log2(DATA_W/8)-1:2] selects the 32-bit word lane within the bus word, and b = addr[1:0] selects the byte within that lane. Little-endian.
- Store byte enables: SB sets bit 4k+b; SH sets bits 4k+b and 4k+b+1; SW sets bits 4k..4k+3. `writedata` holds the data replicated/shifted into those lanes, and unused lanes are 0.
- Loads: all bus byte lanes are enabled. Let W = the 32-bit word in lane k.
  - LB/LBU: byte b of W, sign- or zero-extended.
  - LH/LHU: halfword at b, sign- or zero-extended.
  - LW: W.
- LWL: (W << 8·(3−b)) | (req_rt & ~(0xFFFFFFFF << 8·(3−b))).
- LWR: (W >> 8·b) | (req_rt & ~(0xFFFFFFFF >> 8·b)).
- Requests arriving while `req_ready`=0 are ignored; the core must hold `req_valid` until accepted.

## Timing
- Accepted at cycle 0, then BUS from cycle 1.
- Zero-wait completion: bus strobe in cycle 1, `rsp_valid` in cycle 2, `req_ready` again in cycle 3.
- Each `waitrequest` cycle adds one cycle of latency.
- Misaligned request: no bus strobe, `rsp_valid` in cycle 1.
- `rsp_rdata`/`rsp_err` are valid only while `rsp_valid`=1 and are cleared to 0 in IDLE.
- Reset asserted mid-transaction: `read`/`write` drop immediately (asynchronous), the FSM goes to IDLE, and no `rsp_valid` is produced for the aborted request.
- All outputs are registered; no combinational path exists from `readdata` or `waitrequest` to the outputs.

## Configuration
- `MIPS_MEM_TIMEOUT_EN` defined:
  - A counter increments on every BUS cycle with `waitrequest`=1 and clears on entry to BUS.
  - When the counter reaches `TIMEOUT_CYCLES`, the strobe deasserts, the FSM goes to RESP with `rsp_err`=TIMEOUT and `rsp_rdata`=0.
- Not defined: no counter exists, the unit waits indefinitely, TIMEOUT is never reported, and `TIMEOUT_CYCLES` is unused.

## Structure
- `mips_pkg`: `mem_op_t` (4-bit enum), `rsp_err_t` (2-bit enum) and the FSM state enum, shared with the core decoder.
- Sub-module `mips_load_align`: purely combinational. Takes W, b, op and req_rt; produces the extended/merged 32-bit result. Instantiated once, on registered inputs.

## Test plan
- LW 0x1000, readdata=0xDEADBEEF, `waitrequest` high 2 cycles -> `read` held 3 cycles at `address`=0x1000, `rsp_rdata`=0xDEADBEEF, err 0.
- LB 0x1003 and LBU 0x1003, readdata=0x80FF0000 -> 0xFFFFFF80 and 0x00000080 respectively.
- SH 0x1002, wdata 0x1234ABCD -> `byteenable`=0b1100, `writedata`=0xABCD0000; with DATA_W=64, SW 0x1004 -> `byteenable`=0xF0 and data in the upper lane.
- LWL 0x1001 and LWR 0x1001, memory word 0x44332211, rt=0xAABBCCDD -> 0x2211CCDD and 0xAA443322.
- LW 0x1002 -> no `read` strobe, `rsp_valid` in cycle 1, `rsp_err`=1.
- With `MIPS_MEM_TIMEOUT_EN`, TIMEOUT_CYCLES=8 and `waitrequest` stuck high -> `read` drops after 8 stalled cycles, `rsp_err`=2. Separately, asserting `reset` during a stall -> `read`=0 immediately, no `rsp_valid`, `req_ready`=1.
